rr_arb8: RTL

//  8-way round-robin arbiter sharing one resource among 8 requesters.

---
 rtl/rr_arb8_pkg.sv | 6 +
 rtl/rr_arb8_if.sv | 12 +
 rtl/rr_arb8_dec3to8.sv | 12 +
 rtl/rr_arb8.sv | 98 +++++++++
 4 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;
  typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;
  localparam int NREQ = 8;
  localparam int IDXW = 3;
endpackage

// File: rtl/rr_arb8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arb8_if;
  import arb_pkg::*;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            busy;
  logic            timeout;

  modport master (output req, input gnt, gnt_idx, busy, timeout);
  modport slave  (input req, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/rr_arb8_dec3to8.sv
// One-hot decoder with enable; all outputs low when en=0.
module dec3to8
  import arb_pkg::*;
(
  input  logic [IDXW-1:0] din,
  input  logic            en,
  output logic [NREQ-1:0] dout
);
  for (genvar i = 0; i < NREQ; i++) begin : g_bit
    assign dout[i] = en && (din == IDXW'(i));
  end
endmodule

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with registered winner index and optional hold timeout.
module rr_arb8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 255,
  parameter int CW       = 8
) (
  input  logic     clk,
  input  logic     rst,
  rr_arb8_if.slave bus
);
  localparam int HL = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_t      state, state_n;
  logic [IDXW-1:0] gnt_idx, gnt_idx_n, last, last_n;
  logic [CW-1:0]   hold_cnt, hold_n;
  logic [NREQ-1:0] mask, mask_n, eligible;
  logic            timeout, timeout_n;

  // Circular search beginning just after the last served requester.
  function automatic logic [IDXW-1:0] pick(input logic [NREQ-1:0] el,
                                           input logic [IDXW-1:0] lst);
    logic [IDXW-1:0] idx;
    logic            found;
    pick  = lst;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = lst + IDXW'(k);
      if (!found && el[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign eligible = bus.req & ~mask;

  always_comb begin
    state_n   = state;
    gnt_idx_n = gnt_idx;
    last_n    = last;
    hold_n    = hold_cnt;
    mask_n    = mask & bus.req;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          gnt_idx_n = pick(eligible, last);
          hold_n    = '0;
          state_n   = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[gnt_idx]) begin
          last_n  = gnt_idx;
          state_n = IDLE;
        end else if (MAX_HOLD != 0 && hold_cnt == CW'(HL)) begin
          // Masked until the holder lets go of req for at least one cycle.
          timeout_n       = 1'b1;
          mask_n[gnt_idx] = 1'b1;
          last_n          = gnt_idx;
          state_n         = IDLE;
        end else if (hold_cnt != '1) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last     <= IDXW'(NREQ - 1);
      hold_cnt <= '0;
      mask     <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt_idx  <= gnt_idx_n;
      last     <= last_n;
      hold_cnt <= hold_n;
      mask     <= mask_n;
      timeout  <= timeout_n;
    end
  end

  assign bus.busy    = (state == GRANT);
  assign bus.gnt_idx = gnt_idx;
  assign bus.timeout = timeout;

  dec3to8 u_dec (
    .din  (gnt_idx),
    .en   (bus.busy),
    .dout (bus.gnt)
  );
endmodule
